dma_csr_axil_slave: RTL and testbench
=====================================

Name: dma_csr_axil_slave

Overview:
- AXI4-Lite slave register block for the DMA controller.
- Terminates the DMA slave port: AW/W/B/AR/R channels, driven by the CPU or the testbench.
- Holds the transfer descriptor (src, dst, len) and status.
- Issues a single-cycle start pulse to the DMA engine and collects its busy/done/error status and interrupt.

Parameters:
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 32: AXI data width. Only 32 is supported.
- LEN_WIDTH, 16: transfer length register width, in bytes.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset. Synchronous, active-high. One clock.
- AWADDR  in  ADDR_WIDTH  write address.
- AWVALID  in  1; AWREADY  out  1.
- WDATA  in  DATA_WIDTH; WSTRB  in  DATA_WIDTH/8; WVALID  in  1; WREADY  out  1.
- BRESP  out  2; BVALID  out  1; BREADY  in  1.
- ARADDR  in  ADDR_WIDTH; ARVALID  in  1; ARREADY  out  1.
- RDATA  out  DATA_WIDTH; RRESP  out  2; RVALID  out  1; RREADY  in  1.
- dma_start_o  out  1  one-cycle start pulse.
- dma_src_o  out  ADDR_WIDTH  source address.
- dma_dst_o  out  ADDR_WIDTH  destination address.
- dma_len_o  out  LEN_WIDTH  length in bytes.
- dma_busy_i  in  1  engine busy level.
- dma_done_i  in  1  completion pulse.
- dma_err_i  in  1  error pulse.
- irq_o  out  1  interrupt, level.

Behaviour:
- Register map: decoded on ADDR[4:2]; ADDR[1:0] and bits above 4 are ignored.
  - 0x00 CTRL: bit0 START (write 1 = start request; reads 0), bit1 IRQ_EN (RW).
  - 0x04 STATUS: bit0 BUSY (RO, equals dma_busy_i), bit1 DONE (W1C), bit2 ERR (W1C).
  - 0x08 SRC (RW), 0x0C DST (RW), 0x10 LEN (RW, low LEN_WIDTH bits; upper bits read 0).
  - Offsets 0x14-0x1C: response SLVERR (2'b10). Write is discarded; read returns 0.
  - All other responses are OKAY (2'b00).
- Reset (ARESET=1 at a rising edge):
  - All registers are cleared to 0.
  - AWREADY, WREADY, ARREADY, BVALID, RVALID, dma_start_o and irq_o are 0; BRESP, RRESP and RDATA are 0.
  - Readies rise on the first edge after ARESET falls.
  - Reset mid-transaction drops BVALID/RVALID immediately; the pending transaction is lost.
- Write path FSM, states W_IDLE and W_RESP:
  - In W_IDLE, AW and W are accepted independently, in either order or in the same cycle.
  - Each ready drops after its handshake, until the response completes.
  - The register update occurs on the edge where the second of the two handshakes completes. The FSM enters W_RESP with BVALID=1 on the next cycle.
  - BVALID and BRESP are held stable until BREADY=1. The FSM then returns to W_IDLE, and AWREADY/WREADY reassert on the following cycle.
  - Maximum throughput: one write per 3 cycles.
- Write strobes:
  - SRC, DST and LEN are updated per byte lane by WSTRB.
  - CTRL and STATUS act only if WSTRB[0]=1.
  - WSTRB=0 yields an OKAY response with no change.
- START handling:
  - Write START=1 with dma_busy_i=0 and LEN!=0: dma_start_o=1 for exactly the next cycle.
  - Write START=1 with LEN==0: no pulse; ERR is set.
  - Write START=1 with dma_busy_i=1: ignored, no pulse, no flag.
- DONE/ERR flags:
  - Set by the dma_done_i / dma_err_i pulse; cleared by writing 1 to the corresponding bit.
  - If set and clear occur in the same cycle, set wins.
- Interrupt: irq_o is registered and equals IRQ_EN & (DONE | ERR), with one cycle of lag.
- Read path FSM, states R_IDLE and R_DATA:
  - ARREADY=1 in R_IDLE.
  - On the AR handshake, RDATA and RRESP are captured from current register values, and the FSM enters R_DATA with RVALID=1 on the next cycle.
  - RDATA, RRESP and RVALID are held until RREADY=1; the FSM then returns to R_IDLE.
- Read/write interaction:
  - Read and write paths run concurrently.
  - A read captured on the same edge as a write to the same register returns the old value.

Test Plan:
- Write SRC=0x1000_0000, DST=0x2000_0040, LEN=0x0100 (AW before W, W before AW, same cycle), then read each back -> values match, BRESP=RRESP=OKAY, dma_*_o outputs equal the written values.
- Write 0x3 to CTRL with busy=0, LEN=0x100 -> dma_start_o high exactly 1 cycle. Pulse done_i -> STATUS reads 0x2 and irq_o=1. Write 0x2 to STATUS -> STATUS=0, irq_o=0.
- LEN=0 then write START -> no pulse, STATUS.ERR=1. With busy=1 and LEN=4, write START -> no pulse, ERR unchanged.
- Write SRC=0xFFFF_FFFF then write 0x0000_00AB with WSTRB=4'b0001 -> SRC reads 0xFFFF_FFAB.
- Access 0x18 -> BRESP=RRESP=2'b10, RDATA=0. Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and data stay stable, no new AW/AR accepted.
- Assert ARESET while BVALID=1 -> BVALID=0 on the next edge, all registers 0, readies 1 one cycle after reset release. Same-cycle done_i pulse and DONE W1C -> DONE remains 1.

Source files
------------

// File: rtl/dma_csr_axil_slave_if.sv
// AXI4-Lite bus bundle for the DMA CSR slave port.
// The master drives address/data/ready-for-response; the slave answers.
interface dma_csr_axil_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/dma_csr_axil_slave.sv
// AXI4-Lite CSR block for the DMA engine: descriptor registers, start pulse,
// sticky DONE/ERR flags and a level interrupt.
module dma_csr_axil_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  dma_csr_axil_slave_if.slave   s_axil,
  output logic                  dma_start_o,
  output logic [ADDR_WIDTH-1:0] dma_src_o,
  output logic [ADDR_WIDTH-1:0] dma_dst_o,
  output logic [LEN_WIDTH-1:0]  dma_len_o,
  input  logic                  dma_busy_i,
  input  logic                  dma_done_i,
  input  logic                  dma_err_i,
  output logic                  irq_o
);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  arready_q, arready_d;
  logic                  aw_got_q, aw_got_d;
  logic                  w_got_q, w_got_d;
  logic [2:0]            aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  irq_en_q, irq_en_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  start_q, start_d;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] src_q, src_d;
  logic [DATA_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;

  logic                  aw_fire, w_fire, ar_fire, wr_commit;
  logic [2:0]            wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data, rd_val;
  logic [SW-1:0]         wr_strb;
  logic                  rd_err, start_err, done_clr, err_clr;
  logic                  unused_addr_bits;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [SW-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int b = 0; b < SW; b++)
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

  // AW and W may arrive in any order; whichever completes second is taken live.
  assign aw_fire   = s_axil.AWVALID & awready_q;
  assign w_fire    = s_axil.WVALID & wready_q;
  assign ar_fire   = s_axil.ARVALID & arready_q;
  assign wr_idx    = aw_fire ? s_axil.AWADDR[4:2] : aw_idx_q;
  assign wr_data   = w_fire ? s_axil.WDATA : wdata_q;
  assign wr_strb   = w_fire ? s_axil.WSTRB : wstrb_q;
  assign wr_commit = (w_state_q == W_IDLE) & (aw_got_q | aw_fire) & (w_got_q | w_fire);
  assign rd_idx    = s_axil.ARADDR[4:2];

  assign unused_addr_bits = ^{s_axil.AWADDR[ADDR_WIDTH-1:5], s_axil.AWADDR[1:0],
                              s_axil.ARADDR[ADDR_WIDTH-1:5], s_axil.ARADDR[1:0]};

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_got_d = 1'b1;
          aw_idx_d = s_axil.AWADDR[4:2];
        end
        if (w_fire) begin
          w_got_d = 1'b1;
          wdata_d = s_axil.WDATA;
          wstrb_d = s_axil.WSTRB;
        end
        awready_d = ~(aw_got_q | aw_fire);
        wready_d  = ~(w_got_q | w_fire);
        if (wr_commit) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = (wr_idx >= 3'd5) ? RESP_SLVERR : RESP_OKAY;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end
      end
      W_RESP: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        if (s_axil.BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    irq_en_d  = irq_en_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    start_d   = 1'b0;
    start_err = 1'b0;
    done_clr  = 1'b0;
    err_clr   = 1'b0;
    if (wr_commit) begin
      case (wr_idx)
        3'd0: if (wr_strb[0]) begin
          irq_en_d = wr_data[1];
          // A start request while the engine is busy is silently dropped.
          if (wr_data[0] && !dma_busy_i) begin
            if (len_q == '0) start_err = 1'b1;
            else             start_d   = 1'b1;
          end
        end
        3'd1: if (wr_strb[0]) begin
          done_clr = wr_data[1];
          err_clr  = wr_data[2];
        end
        3'd2: src_d = merge_bytes(src_q, wr_data, wr_strb);
        3'd3: dst_d = merge_bytes(dst_q, wr_data, wr_strb);
        3'd4: len_d = LEN_WIDTH'(merge_bytes(DATA_WIDTH'(len_q), wr_data, wr_strb));
        default: ;
      endcase
    end
    done_d = (done_q & ~done_clr) | dma_done_i;
    err_d  = (err_q & ~err_clr) | dma_err_i | start_err;
    irq_d  = irq_en_q & (done_q | err_q);
  end

  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (rd_idx)
      3'd0: rd_val[1] = irq_en_q;
      3'd1: begin
        rd_val[0] = dma_busy_i;
        rd_val[1] = done_q;
        rd_val[2] = err_q;
      end
      3'd2: rd_val = src_q;
      3'd3: rd_val = dst_q;
      3'd4: rd_val[LEN_WIDTH-1:0] = len_q;
      default: rd_err = 1'b1;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_fire) begin
          arready_d = 1'b0;
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rdata_d   = rd_val;
          rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      R_DATA: begin
        arready_d = 1'b0;
        if (s_axil.RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      start_q   <= start_d;
      irq_q     <= irq_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
    end
  end

  assign s_axil.AWREADY = awready_q;
  assign s_axil.WREADY  = wready_q;
  assign s_axil.BVALID  = bvalid_q;
  assign s_axil.BRESP   = bresp_q;
  assign s_axil.ARREADY = arready_q;
  assign s_axil.RVALID  = rvalid_q;
  assign s_axil.RRESP   = rresp_q;
  assign s_axil.RDATA   = rdata_q;
  assign dma_start_o    = start_q;
  assign dma_src_o      = ADDR_WIDTH'(src_q);
  assign dma_dst_o      = ADDR_WIDTH'(dst_q);
  assign dma_len_o      = len_q;
  assign irq_o          = irq_q;
endmodule

// File: tb/tb_dma_csr_axil_slave.sv
// Directed bench for the DMA CSR slave; responses are checked by a scoreboard
// monitor that pops expected B/R beats on each handshake.
module tb_dma_csr_axil_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic        dma_start, busy, done_p, err_p, irq;
  logic [31:0] src, dst;
  logic [15:0] len;

  dma_csr_axil_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dma_csr_axil_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .ACLK        (clk),
    .ARESET      (rst),
    .s_axil      (bus),
    .dma_start_o (dma_start),
    .dma_src_o   (src),
    .dma_dst_o   (dst),
    .dma_len_o   (len),
    .dma_busy_i  (busy),
    .dma_done_i  (done_p),
    .dma_err_i   (err_p),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] SLV = 2'b10;

  int          total = 0;
  int          bad = 0;
  int          start_cnt = 0;
  int          c0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [1:0]  eb;
  logic [33:0] er;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: sampled mid-cycle, one beat per handshake.
  always @(negedge clk) begin
    if (!rst && dma_start) start_cnt++;
    if (!rst && bus.BVALID && bus.BREADY) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected: got resp %0d with empty queue", bus.BRESP);
      end else begin
        eb = exp_b.pop_front();
        chk("bresp", bus.BRESP, eb);
      end
    end
    if (!rst && bus.RVALID && bus.RREADY) begin
      if (exp_r.size() == 0) begin
        total++; bad++;
        $display("FAIL r_unexpected: got data 0x%08h with empty queue", bus.RDATA);
      end else begin
        er = exp_r.pop_front();
        chk("rresp", bus.RRESP, er[33:32]);
        chk("rdata", bus.RDATA, er[31:0]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // order: 0 = AW first, 1 = W first, 2 = same cycle
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int order, input int stall,
                           input logic [1:0] resp);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_hs, w_hs;
    int n = 0;
    exp_b.push_back(resp);
    bus.BREADY  = (stall == 0);
    bus.AWADDR  = addr;
    bus.WDATA   = data;
    bus.WSTRB   = strb;
    bus.AWVALID = (order != 1);
    bus.WVALID  = (order != 0);
    while (!(aw_done && w_done) && n < 40) begin
      @(negedge clk);
      aw_hs = bus.AWVALID && bus.AWREADY;
      w_hs  = bus.WVALID && bus.WREADY;
      @(posedge clk); #1;
      n++;
      if (aw_hs) begin aw_done = 1; bus.AWVALID = 0; end
      if (w_hs) begin w_done = 1; bus.WVALID = 0; end
      if (aw_done && !w_done) bus.WVALID = 1;
      if (w_done && !aw_done) bus.AWVALID = 1;
    end
    if (!(aw_done && w_done)) begin
      total++; bad++;
      $display("FAIL wr_handshake_timeout: addr 0x%08h aw=%0d w=%0d", addr, aw_done, w_done);
      bus.AWVALID = 0; bus.WVALID = 0; bus.BREADY = 0;
      void'(exp_b.pop_back());
      return;
    end
    n = 0;
    while (!bus.BVALID && n < 40) begin @(posedge clk); #1; n++; end
    if (!bus.BVALID) begin
      total++; bad++;
      $display("FAIL bvalid_timeout: addr 0x%08h bvalid=%0d", addr, bus.BVALID);
      bus.BREADY = 0;
      void'(exp_b.pop_back());
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("b_stall_valid", bus.BVALID, 1);
      chk("b_stall_resp", bus.BRESP, resp);
      chk("b_stall_awready", bus.AWREADY, 0);
      chk("b_stall_wready", bus.WREADY, 0);
      @(posedge clk); #1;
    end
    bus.BREADY = 1;
    @(posedge clk); #1;
    bus.BREADY = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input int stall);
    bit hs = 0;
    int n = 0;
    exp_r.push_back({resp, data});
    bus.RREADY  = (stall == 0);
    bus.ARADDR  = addr;
    bus.ARVALID = 1;
    while (!hs && n < 40) begin
      @(negedge clk);
      hs = bus.ARVALID && bus.ARREADY;
      @(posedge clk); #1;
      n++;
    end
    bus.ARVALID = 0;
    n = 0;
    while (hs && !bus.RVALID && n < 40) begin @(posedge clk); #1; n++; end
    if (!hs || !bus.RVALID) begin
      total++; bad++;
      $display("FAIL rd_timeout: addr 0x%08h ar_hs=%0d rvalid=%0d", addr, hs, bus.RVALID);
      bus.RREADY = 0;
      void'(exp_r.pop_back());
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("r_stall_valid", bus.RVALID, 1);
      chk("r_stall_resp", bus.RRESP, resp);
      chk("r_stall_data", bus.RDATA, data);
      chk("r_stall_arready", bus.ARREADY, 0);
      @(posedge clk); #1;
    end
    bus.RREADY = 1;
    @(posedge clk); #1;
    bus.RREADY = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1; busy = 0; done_p = 0; err_p = 0;
    bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0;
    bus.BREADY = 0; bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", bus.AWREADY, 0);
    chk("rst_arready", bus.ARREADY, 0);
    chk("rst_bvalid", bus.BVALID, 0);
    chk("rst_rvalid", bus.RVALID, 0);
    chk("rst_start", dma_start, 0);
    chk("rst_irq", irq, 0);
    rst = 0;
    idle(1);
    chk("rel_awready", bus.AWREADY, 1);
    chk("rel_wready", bus.WREADY, 1);
    chk("rel_arready", bus.ARREADY, 1);

    // descriptor writes in all three channel orders
    axi_write(32'h08, 32'h1000_0000, 4'hF, 0, 0, OK);
    axi_write(32'h0C, 32'h2000_0040, 4'hF, 1, 0, OK);
    axi_write(32'h10, 32'h0000_0100, 4'hF, 2, 0, OK);
    chk("src_o", src, 32'h1000_0000);
    chk("dst_o", dst, 32'h2000_0040);
    chk("len_o", len, 16'h0100);
    axi_read(32'h08, 32'h1000_0000, OK, 0);
    axi_read(32'h0C, 32'h2000_0040, OK, 0);
    axi_read(32'h10, 32'h0000_0100, OK, 0);
    axi_read(32'h2B, 32'h1000_0000, OK, 0);

    // start pulse, DONE, interrupt, W1C
    c0 = start_cnt;
    axi_write(32'h00, 32'h3, 4'hF, 2, 0, OK);
    idle(3);
    chk("start_pulse_cnt", start_cnt - c0, 1);
    axi_read(32'h00, 32'h2, OK, 0);
    done_p = 1; idle(1); done_p = 0; idle(1);
    chk("irq_on_done", irq, 1);
    axi_read(32'h04, 32'h2, OK, 0);
    axi_write(32'h04, 32'h2, 4'hF, 0, 0, OK);
    idle(1);
    chk("irq_cleared", irq, 0);
    axi_read(32'h04, 32'h0, OK, 0);

    // START with LEN==0, then while busy
    axi_write(32'h10, 32'h0, 4'hF, 2, 0, OK);
    c0 = start_cnt;
    axi_write(32'h00, 32'h3, 4'hF, 2, 0, OK);
    idle(3);
    chk("len0_no_pulse", start_cnt - c0, 0);
    axi_read(32'h04, 32'h4, OK, 0);
    chk("irq_on_err", irq, 1);
    busy = 1;
    axi_write(32'h10, 32'h4, 4'hF, 2, 0, OK);
    c0 = start_cnt;
    axi_write(32'h00, 32'h3, 4'hF, 1, 0, OK);
    idle(3);
    chk("busy_no_pulse", start_cnt - c0, 0);
    axi_read(32'h04, 32'h5, OK, 0);
    busy = 0;
    axi_write(32'h04, 32'h4, 4'hF, 2, 0, OK);
    axi_read(32'h04, 32'h0, OK, 0);

    // byte strobes
    axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, 2, 0, OK);
    axi_write(32'h08, 32'h0000_00AB, 4'b0001, 2, 0, OK);
    axi_read(32'h08, 32'hFFFF_FFAB, OK, 0);
    axi_write(32'h0C, 32'h0, 4'b0000, 2, 0, OK);
    axi_read(32'h0C, 32'h2000_0040, OK, 0);
    axi_write(32'h10, 32'hFFFF_5600, 4'b0010, 0, 0, OK);
    axi_write(32'h10, 32'hFFFF_FFFF, 4'b1100, 1, 0, OK);
    axi_read(32'h10, 32'h0000_5604, OK, 0);

    // reserved window, with backpressure on B and R
    axi_write(32'h18, 32'hDEAD_BEEF, 4'hF, 2, 5, SLV);
    axi_read(32'h18, 32'h0, SLV, 5);
    axi_read(32'h14, 32'h0, SLV, 0);
    axi_read(32'h1C, 32'h0, SLV, 0);
    axi_read(32'h08, 32'hFFFF_FFAB, OK, 0);

    // reset while a write response is pending
    bus.AWADDR = 32'h0C; bus.WDATA = 32'h55; bus.WSTRB = 4'hF;
    bus.AWVALID = 1; bus.WVALID = 1; bus.BREADY = 0;
    idle(1);
    bus.AWVALID = 0; bus.WVALID = 0;
    n = 0;
    while (!bus.BVALID && n < 20) begin idle(1); n++; end
    chk("pre_rst_bvalid", bus.BVALID, 1);
    rst = 1;
    idle(1);
    chk("mid_rst_bvalid", bus.BVALID, 0);
    chk("mid_rst_awready", bus.AWREADY, 0);
    chk("mid_rst_src", src, 0);
    chk("mid_rst_dst", dst, 0);
    chk("mid_rst_len", len, 0);
    rst = 0;
    idle(1);
    chk("post_rst_awready", bus.AWREADY, 1);
    chk("post_rst_wready", bus.WREADY, 1);
    chk("post_rst_arready", bus.ARREADY, 1);
    idle(1);
    chk("post_rst_irq", irq, 0);
    axi_read(32'h00, 32'h0, OK, 0);
    axi_read(32'h04, 32'h0, OK, 0);
    axi_read(32'h08, 32'h0, OK, 0);
    axi_read(32'h10, 32'h0, OK, 0);

    // DONE set and W1C on the same edge: set wins
    done_p = 1; idle(1); done_p = 0;
    axi_read(32'h04, 32'h2, OK, 0);
    idle(2);
    exp_b.push_back(OK);
    bus.AWADDR = 32'h04; bus.WDATA = 32'h2; bus.WSTRB = 4'hF;
    bus.AWVALID = 1; bus.WVALID = 1; bus.BREADY = 1; done_p = 1;
    idle(1);
    done_p = 0; bus.AWVALID = 0; bus.WVALID = 0;
    chk("same_edge_hs_taken", bus.AWREADY, 0);
    n = 0;
    while (!bus.BVALID && n < 20) begin idle(1); n++; end
    chk("same_edge_bvalid", bus.BVALID, 1);
    idle(1);
    bus.BREADY = 0;
    axi_read(32'h04, 32'h2, OK, 0);
    axi_write(32'h04, 32'h2, 4'hF, 2, 0, OK);
    axi_read(32'h04, 32'h0, OK, 0);

    idle(3);
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      total++; bad++;
      $display("FAIL leftover_expectations: b=%0d r=%0d", exp_b.size(), exp_r.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
